// File: rtl/score_digit_renderer.sv
// score_digit_renderer
//   Converts the 8-bit player score to three BCD digits with a sequential
//   double-dabble FSM, holds the result until the next frame boundary, and
//   draws the shown digits as seven-segment glyphs into the pixel stream.
//
//   Optional build macro: SCORE_LEADING_ZERO_BLANK_EN
//     defined   -> leading zero digits are blanked ("0", "7", "40")
//     undefined -> all three digits are always drawn ("000", "007", "040")
//
//   Ports
//     clk_25MHz      in   pixel clock
//     reset          in   asynchronous active-low reset
//     score[7:0]     in   binary score
//     frame_start    in   one-cycle pulse at start of vertical blanking
//     display_enable in   x_pixel/y_pixel are in the visible area
//     x_pixel[9:0]   in   current pixel column
//     y_pixel[9:0]   in   current pixel row
//     busy           out  conversion in progress (SHIFT or DONE)
//     score_pixel_on out  registered: pixel lies on a lit segment
//     rgb_out[11:0]  out  registered: FG_COLOR when lit, else 0
//
//   state | meaning
//   IDLE  | waiting for score to differ from the last converted value
//   SHIFT | one double-dabble iteration per cycle, 8 in total
//   DONE  | publish BCD result as pending, return to IDLE

module score_digit_renderer #(
    parameter int unsigned ORIGIN_X  = 16,
    parameter int unsigned ORIGIN_Y  = 16,
    parameter int unsigned SEG_LEN   = 16,
    parameter int unsigned SEG_THK   = 4,
    parameter int unsigned DIGIT_GAP = 8,
    parameter logic [11:0] FG_COLOR  = 12'hFFF
) (
    input  logic        clk_25MHz,
    input  logic        reset,
    input  logic [7:0]  score,
    input  logic        frame_start,
    input  logic        display_enable,
    input  logic [9:0]  x_pixel,
    input  logic [9:0]  y_pixel,
    output logic        busy,
    output logic        score_pixel_on,
    output logic [11:0] rgb_out
);

    localparam logic [10:0] T_C  = 11'(SEG_THK);
    localparam logic [10:0] L_C  = 11'(SEG_LEN);
    localparam logic [10:0] W_C  = 11'(SEG_LEN + 2 * SEG_THK);
    localparam logic [10:0] H_C  = 11'(2 * SEG_LEN + 3 * SEG_THK);
    localparam logic [10:0] X0_C = 11'(ORIGIN_X);
    localparam logic [10:0] Y0_C = 11'(ORIGIN_Y);
    localparam logic [10:0] PITCH_C = 11'(SEG_LEN + 2 * SEG_THK + DIGIT_GAP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  score_seen_q, score_seen_d;
    logic [7:0]  bin_q, bin_d;
    logic [11:0] bcd_q, bcd_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [11:0] pending_bcd_q, pending_bcd_d;
    logic        pending_valid_q, pending_valid_d;
    logic [11:0] shown_q, shown_d;
    logic        pix_on_q, pix_on_d;
    logic [11:0] rgb_q, rgb_d;

    logic [11:0] bcd_adj;
    logic [19:0] shifted;

    // Segment bit order: [0]=a [1]=b [2]=c [3]=d [4]=e [5]=f [6]=g
    function automatic logic [6:0] seg_map(input logic [3:0] dig);
        logic [6:0] s;
        case (dig)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Pixels left of or above the glyph origin are rejected before the
    // subtraction so they can never wrap into the glyph box.
    function automatic logic digit_hit(
        input logic [10:0] px,
        input logic [10:0] py,
        input logic [10:0] x0,
        input logic [3:0]  dig
    );
        logic [10:0] dx, dy;
        logic [6:0]  s;
        logic        h_span, left, right;
        logic        row_a, row_g, row_d, upper, lower;
        logic        hit;
        hit = 1'b0;
        dx  = px - x0;
        dy  = py - Y0_C;
        s   = seg_map(dig);
        h_span = (dx >= T_C) && (dx < T_C + L_C);
        left   = (dx < T_C);
        right  = (dx >= T_C + L_C) && (dx < W_C);
        row_a  = (dy < T_C);
        row_g  = (dy >= T_C + L_C) && (dy < 2 * T_C + L_C);
        row_d  = (dy >= 2 * T_C + 2 * L_C) && (dy < H_C);
        upper  = (dy >= T_C) && (dy < T_C + L_C);
        lower  = (dy >= 2 * T_C + L_C) && (dy < 2 * T_C + 2 * L_C);
        if ((px >= x0) && (py >= Y0_C)) begin
            hit = (s[0] && h_span && row_a) ||
                  (s[6] && h_span && row_g) ||
                  (s[3] && h_span && row_d) ||
                  (s[5] && left   && upper) ||
                  (s[1] && right  && upper) ||
                  (s[4] && left   && lower) ||
                  (s[2] && right  && lower);
        end
        return hit;
    endfunction

    always_comb begin
        state_d         = state_q;
        score_seen_d    = score_seen_q;
        bin_d           = bin_q;
        bcd_d           = bcd_q;
        cnt_d           = cnt_q;
        pending_bcd_d   = pending_bcd_q;
        pending_valid_d = pending_valid_q;
        shown_d         = shown_q;
        bcd_adj         = bcd_q;
        shifted         = {bcd_q, bin_q};

        case (state_q)
            ST_IDLE: begin
                if (score != score_seen_q) begin
                    bin_d        = score;
                    score_seen_d = score;
                    bcd_d        = 12'h000;
                    cnt_d        = 3'd0;
                    state_d      = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                for (int n = 0; n < 3; n++) begin
                    if (bcd_q[n*4 +: 4] >= 4'd5) begin
                        bcd_adj[n*4 +: 4] = bcd_q[n*4 +: 4] + 4'd3;
                    end
                end
                shifted = {bcd_adj, bin_q} << 1;
                bcd_d   = shifted[19:8];
                bin_d   = shifted[7:0];
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Commit sees the old pending value; a result finishing in the same
        // cycle re-arms pending_valid and waits for the next frame.
        if (frame_start && pending_valid_q) begin
            shown_d         = pending_bcd_q;
            pending_valid_d = 1'b0;
        end
        if (state_q == ST_DONE) begin
            pending_bcd_d   = bcd_q;
            pending_valid_d = 1'b1;
        end
    end

    logic [2:0]  blank;
    logic [3:0]  digit_val [3];
    logic        lit;
    logic [10:0] px, py;

    always_comb begin
        px           = {1'b0, x_pixel};
        py           = {1'b0, y_pixel};
        digit_val[0] = shown_q[11:8];
        digit_val[1] = shown_q[7:4];
        digit_val[2] = shown_q[3:0];
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        blank[0] = (shown_q[11:8] == 4'd0);
        blank[1] = (shown_q[11:8] == 4'd0) && (shown_q[7:4] == 4'd0);
        blank[2] = 1'b0;
`else
        blank = 3'b000;
`endif
        lit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (!blank[i] &&
                digit_hit(px, py, X0_C + 11'(i) * PITCH_C, digit_val[i])) begin
                lit = 1'b1;
            end
        end
        pix_on_d = display_enable && lit;
        rgb_d    = pix_on_d ? FG_COLOR : 12'h000;
    end

    always_ff @(posedge clk_25MHz or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            score_seen_q    <= 8'd0;
            bin_q           <= 8'd0;
            bcd_q           <= 12'h000;
            cnt_q           <= 3'd0;
            pending_bcd_q   <= 12'h000;
            pending_valid_q <= 1'b0;
            shown_q         <= 12'h000;
            pix_on_q        <= 1'b0;
            rgb_q           <= 12'h000;
        end else begin
            state_q         <= state_d;
            score_seen_q    <= score_seen_d;
            bin_q           <= bin_d;
            bcd_q           <= bcd_d;
            cnt_q           <= cnt_d;
            pending_bcd_q   <= pending_bcd_d;
            pending_valid_q <= pending_valid_d;
            shown_q         <= shown_d;
            pix_on_q        <= pix_on_d;
            rgb_q           <= rgb_d;
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign score_pixel_on = pix_on_q;
    assign rgb_out        = rgb_q;

endmodule
